drug_infusion_sequencer: RTL and testbench

//  Downstream of the heart monitoring block. Consumes its drug_delivery_activate, iv_line_setup and

---
 rtl/infusion_pkg.sv | 30 +++
 rtl/drug_infusion_sequencer_if.sv | 29 ++
 rtl/infusion_timer.sv | 21 ++
 rtl/drug_infusion_sequencer.sv | 115 +++++++++++
 tb/tb_drug_infusion_sequencer.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/infusion_pkg.sv
// Shared state encoding and default timing constants for the adenosine infusion sequencer.
package infusion_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRIME   = 3'd1,
        S_INJECT  = 3'd2,
        S_FLUSH   = 3'd3,
        S_LOCKOUT = 3'd4,
        S_FAULT   = 3'd5
    } inf_state_t;

    localparam int IV_PRIME_CYCLES_D = 16;
    localparam int CYCLES_PER_MG_D   = 8;
    localparam int FLUSH_CYCLES_D    = 10;
    localparam int LOCKOUT_CYCLES_D  = 64;
    localparam int MAX_DOSE_MG_D     = 12;

    // Timer must hold the longest phase length loaded into it.
    function automatic int tmr_width(input int max_dose, input int cpm, input int lockout,
                                     input int prime, input int flush);
        int m;
        m = max_dose * cpm;
        if (lockout > m) m = lockout;
        if (prime > m)   m = prime;
        if (flush > m)   m = flush;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/drug_infusion_sequencer_if.sv
// Request/status bundle between the heart-monitor side and the infusion sequencer.
interface drug_infusion_sequencer_if;

    logic       drug_req;
    logic       iv_req;
    logic [3:0] dose_mg;
    logic       abort;
    logic       line_occluded;
    logic       fault_clr;
    logic       iv_prime;
    logic       drug_pump_en;
    logic       saline_pump_en;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       fault;
    logic [3:0] delivered_mg;

    modport master (
        output drug_req, iv_req, dose_mg, abort, line_occluded, fault_clr,
        input  iv_prime, drug_pump_en, saline_pump_en, busy, done, aborted, fault, delivered_mg
    );

    modport slave (
        input  drug_req, iv_req, dose_mg, abort, line_occluded, fault_clr,
        output iv_prime, drug_pump_en, saline_pump_en, busy, done, aborted, fault, delivered_mg
    );

endinterface

// File: rtl/infusion_timer.sv
// Loadable down-counter with zero flag; parks at zero rather than wrapping.
module infusion_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (!rst)            cnt <= '0;
        else if (load)       cnt <= load_val;
        else if (cnt != '0)  cnt <= cnt - W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/drug_infusion_sequencer.sv
// Adenosine one-shot sequencer: prime IV line, inject dose, saline flush, lockout.
// Handles abort, occlusion fault and dose clamping; all outputs registered.
module drug_infusion_sequencer
    import infusion_pkg::*;
#(
    parameter int IV_PRIME_CYCLES = IV_PRIME_CYCLES_D,
    parameter int CYCLES_PER_MG   = CYCLES_PER_MG_D,
    parameter int FLUSH_CYCLES    = FLUSH_CYCLES_D,
    parameter int LOCKOUT_CYCLES  = LOCKOUT_CYCLES_D,
    parameter int MAX_DOSE_MG     = MAX_DOSE_MG_D
) (
    input logic                       clk,
    input logic                       rst,
    drug_infusion_sequencer_if.slave  bus
);

    localparam int TW = tmr_width(MAX_DOSE_MG, CYCLES_PER_MG, LOCKOUT_CYCLES,
                                  IV_PRIME_CYCLES, FLUSH_CYCLES);

    inf_state_t    state, nxt;
    logic [TW-1:0] tmr_cnt, tmr_val;
    logic          tmr_zero, tmr_load;
    logic [3:0]    dose_q, delivered_q, dose_clamped;
    logic          iv_prime_q, drug_pump_q, saline_pump_q;
    logic          busy_q, done_q, aborted_q, fault_q;
    logic          start, abort_take, blk_end, inc;

    infusion_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .cnt      (tmr_cnt),
        .zero     (tmr_zero)
    );

    // Occlusion is checked first so it beats a same-cycle abort or timer expiry.
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:    if (bus.drug_req && bus.iv_req && bus.dose_mg != 4'd0) nxt = S_PRIME;
            S_PRIME:   if (bus.line_occluded)  nxt = S_FAULT;
                       else if (bus.abort)     nxt = S_FLUSH;
                       else if (tmr_zero)      nxt = S_INJECT;
            S_INJECT:  if (bus.line_occluded)  nxt = S_FAULT;
                       else if (bus.abort)     nxt = S_FLUSH;
                       else if (tmr_zero)      nxt = S_FLUSH;
            S_FLUSH:   if (bus.line_occluded)  nxt = S_FAULT;
                       else if (tmr_zero)      nxt = S_LOCKOUT;
            S_LOCKOUT: if (tmr_zero)           nxt = S_IDLE;
            S_FAULT:   if (bus.fault_clr && !bus.line_occluded) nxt = S_IDLE;
            default:   nxt = S_IDLE;
        endcase
    end

    // Timer holds (phase length - 1) so each phase lasts exactly its cycle count.
    always_comb begin
        tmr_load = (nxt != state);
        case (nxt)
            S_PRIME:   tmr_val = TW'(IV_PRIME_CYCLES - 1);
            S_INJECT:  tmr_val = TW'(32'(dose_q) * CYCLES_PER_MG - 1);
            S_FLUSH:   tmr_val = TW'(FLUSH_CYCLES - 1);
            S_LOCKOUT: tmr_val = TW'(LOCKOUT_CYCLES - 1);
            default:   tmr_val = '0;
        endcase
    end

    assign dose_clamped = (bus.dose_mg > 4'(MAX_DOSE_MG)) ? 4'(MAX_DOSE_MG) : bus.dose_mg;
    assign start        = (state == S_IDLE) && (nxt == S_PRIME);
    assign abort_take   = (state == S_PRIME || state == S_INJECT) && !bus.line_occluded && bus.abort;
    // Remaining inject cycles a multiple of CYCLES_PER_MG marks the end of a 1 mg block.
    assign blk_end      = ((32'(tmr_cnt) % CYCLES_PER_MG) == 0);
    assign inc          = (state == S_INJECT) && !bus.line_occluded && !bus.abort &&
                          blk_end && (delivered_q < dose_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= S_IDLE;
            dose_q        <= '0;
            delivered_q   <= '0;
            iv_prime_q    <= 1'b0;
            drug_pump_q   <= 1'b0;
            saline_pump_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state         <= nxt;
            iv_prime_q    <= (nxt == S_PRIME);
            drug_pump_q   <= (nxt == S_INJECT);
            saline_pump_q <= (nxt == S_FLUSH);
            busy_q        <= (nxt != S_IDLE);
            done_q        <= (state == S_FLUSH) && (nxt == S_LOCKOUT);
            fault_q       <= (nxt == S_FAULT);
            if (start) begin
                dose_q      <= dose_clamped;
                delivered_q <= '0;
                aborted_q   <= 1'b0;
            end
            if (abort_take) aborted_q   <= 1'b1;
            if (inc)        delivered_q <= delivered_q + 4'd1;
        end
    end

    assign bus.iv_prime       = iv_prime_q;
    assign bus.drug_pump_en   = drug_pump_q;
    assign bus.saline_pump_en = saline_pump_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.aborted        = aborted_q;
    assign bus.fault          = fault_q;
    assign bus.delivered_mg   = delivered_q;

endmodule

// File: tb/tb_drug_infusion_sequencer.sv
// Randomized bench: expected outputs come from a phase-timeline model built from the sequence rules.
module tb_drug_infusion_sequencer;

    localparam int PRIME = 16, CPM = 8, FLUSH = 10, LOCK = 64, MAXD = 12;

    logic clk = 1'b0;
    logic rst;
    int   total = 0, bad = 0;
    logic [10:0] idle_exp;
    logic [10:0] obs;

    drug_infusion_sequencer_if bus();

    drug_infusion_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign obs = {bus.iv_prime, bus.drug_pump_en, bus.saline_pump_en, bus.busy,
                  bus.done, bus.aborted, bus.fault, bus.delivered_mg};

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output vector for cycle k after the start edge. pl/il = prime/inject lengths,
    // mode 1/2 = abort in prime/inject, mode 3 = occlusion after flush cycle x.
    function automatic logic [10:0] exp_out(input int k, input int pl, input int il,
                                            input int mode, input int x, input int dfin);
        bit iv = 0, pu = 0, sa = 0, bz, dn = 0, ab, ft = 0;
        int del = dfin;
        int fs = pl + il;
        int ls = fs + FLUSH;
        ab = (mode == 1 || mode == 2) && (k > fs);
        if (k <= pl)                          begin iv = 1; del = 0; end
        else if (k <= fs)                     begin pu = 1; del = (k - pl - 1) / CPM; end
        else if (mode == 3 && k > fs + x)     ft = 1;
        else if (k <= ls)                     sa = 1;
        else if (k == ls + 1)                 dn = 1;
        bz = (k <= ls + LOCK) || ft;
        return {iv, pu, sa, bz, dn, ab, ft, 4'(del)};
    endfunction

    task automatic ignore_req(input bit dreq, input bit ireq, input int dose);
        bus.drug_req = dreq; bus.iv_req = ireq; bus.dose_mg = 4'(dose);
        tick();
        bus.drug_req = 0; bus.iv_req = 0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ignore d%0d i%0d m%0d c%0d", dreq, ireq, dose, i), obs, idle_exp);
            tick();
        end
    endtask

    task automatic run_seq(input int dose, input int mode, input int x);
        int d, pl, il, dfin, fs, ls, kend;
        logic [10:0] fvec;
        d    = (dose > MAXD) ? MAXD : dose;
        pl   = (mode == 1) ? x : PRIME;
        il   = (mode == 1) ? 0 : (mode == 2) ? x : d * CPM;
        dfin = (mode == 1) ? 0 : (mode == 2) ? x / CPM : d;
        fs   = pl + il;
        ls   = fs + FLUSH;
        kend = (mode == 3) ? fs + x + 1 : ls + LOCK + 1;
        bus.drug_req = 1; bus.iv_req = 1; bus.dose_mg = 4'(dose);
        tick();
        bus.drug_req = 0; bus.iv_req = 0; bus.dose_mg = 4'($urandom);
        for (int k = 1; k <= kend; k++) begin
            if (k > 1) tick();
            chk($sformatf("seq m%0d d%0d x%0d k%0d", mode, dose, x, k), obs,
                exp_out(k, pl, il, mode, x, dfin));
            bus.abort = (mode == 1 && k == x) || (mode == 2 && k == pl + x) ||
                        (k > fs && k < kend && $urandom_range(0, 3) == 0);
            bus.line_occluded = (mode == 3 && k >= fs + x);
            bus.fault_clr = (k < kend && $urandom_range(0, 3) == 0);
            if (mode != 3 && k == ls + 10) begin
                bus.drug_req = 1; bus.iv_req = 1; bus.dose_mg = 4'($urandom_range(1, 15));
            end else begin
                bus.drug_req = 0; bus.iv_req = 0;
            end
        end
        bus.abort = 0; bus.fault_clr = 0;
        if (mode == 3) begin
            fvec = {3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 4'(dfin)};
            bus.fault_clr = 1;
            tick();
            chk("fault clr while occluded", obs, fvec);
            bus.fault_clr = 0; bus.line_occluded = 0;
            tick();
            chk("fault hold no clr", obs, fvec);
            bus.fault_clr = 1;
            tick();
            idle_exp = {7'b0, 4'(dfin)};
            chk("fault exit", obs, idle_exp);
            bus.fault_clr = 0;
        end else begin
            idle_exp = exp_out(kend, pl, il, mode, x, dfin);
        end
    endtask

    initial begin
        int mode, dose, d, x;
        rst = 0;
        bus.drug_req = 0; bus.iv_req = 0; bus.dose_mg = 0;
        bus.abort = 0; bus.line_occluded = 0; bus.fault_clr = 0;
        idle_exp = '0;
        repeat (3) tick();
        chk("reset outputs", obs, 11'd0);
        bus.drug_req = 1; bus.iv_req = 1; bus.dose_mg = 4'd5;
        tick();
        chk("req under reset", obs, 11'd0);
        bus.drug_req = 0; bus.iv_req = 0;
        rst = 1;
        tick();
        chk("idle after reset", obs, 11'd0);

        ignore_req(1, 0, 6);
        ignore_req(1, 1, 0);
        ignore_req(0, 1, 6);

        run_seq(6, 0, 0);
        run_seq(15, 0, 0);
        run_seq(6, 2, 21);
        ignore_req(1, 1, 0);
        run_seq(4, 3, 3);
        run_seq(1, 3, 10);
        run_seq(12, 1, 15);

        for (int s = 0; s < 16; s++) begin
            mode = $urandom_range(0, 3);
            dose = $urandom_range(1, 15);
            d    = (dose > MAXD) ? MAXD : dose;
            x    = 0;
            if (mode == 1) x = $urandom_range(1, PRIME - 1);
            if (mode == 2) begin
                x = $urandom_range(1, d * CPM - 1);
                if (x % CPM == 0) x = x - 1;
            end
            if (mode == 3) x = $urandom_range(1, FLUSH);
            run_seq(dose, mode, x);
        end

        // Reset pulse during inject cycle 20 of a 6 mg dose
        bus.drug_req = 1; bus.iv_req = 1; bus.dose_mg = 4'd6;
        tick();
        bus.drug_req = 0; bus.iv_req = 0;
        repeat (35) tick();
        chk("inject before reset", obs, exp_out(36, PRIME, 6 * CPM, 0, 0, 6));
        rst = 0;
        tick();
        chk("reset mid inject", obs, 11'd0);
        rst = 1;
        tick();
        chk("idle after mid reset", obs, 11'd0);
        idle_exp = '0;
        ignore_req(0, 0, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
